hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS32 core. It drives the enable and flush inputs of the PC, IF/ID and ID/EX registers, handling four situations:
- load-use hazards, detected between the ID stage and the EX-stage outputs of the ID/EX register;
- branch/jump redirects resolved in EX;
- data-memory wait states;
- two saturating performance counters (stall cycles, bubbles inserted).

## Interface

Parameters:
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rs_ID  in  5  source register rs of the instruction in ID
- rt_ID  in  5  source register rt of the instruction in ID
- uses_rt_ID  in  1  instruction in ID reads rt
- rd_EX  in  5  destination register at the ID/EX output
- mem_rd_EX  in  1  EX instruction is a load
- reg_wr_EX  in  1  EX instruction writes a register
- jump_EX  in  1  jump resolved in EX
- branch_taken_EX  in  1  conditional branch resolved taken in EX
- mem_busy  in  1  data memory not ready; the MEM access must be held
- pc_en  out  1  PC load enable
- if_id_en  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID synchronous clear
- id_ex_en  out  1  ID/EX enable
- id_ex_flush  out  1  ID/EX synchronous clear (bubble insert)
- stall_cnt  out  CNT_W  cycles with pc_en low
- flush_cnt  out  CNT_W  cycles with id_ex_flush high

## Operation

State register holds one of three states: RUN, REDIRECT, MEM_WAIT. Reset value is RUN.

Derived signals:
- lu = mem_rd_EX & reg_wr_EX & (rd_EX != 0) & ((rd_EX == rs_ID) | (uses_rt_ID & rd_EX == rt_ID))
- redir = jump_EX | branch_taken_EX

Outputs are combinational from state and inputs. Default values: all enables 1, all flushes 0. Evaluate in this priority order:
1. mem_busy (any state): pc_en = if_id_en = id_ex_en = 0, no flush. Next state is MEM_WAIT.
2. redir, in RUN or REDIRECT: pc_en = 1 (loads the target), if_id_flush = 1, id_ex_flush = 1. Next state is REDIRECT.
3. State REDIRECT, no redir: if_id_flush = 1, lu ignored because ID holds a bubble. Next state is RUN.
4. State MEM_WAIT, mem_busy low: all enables 1, no flush; this releases the held access. Next state is RUN. lu/redir are not evaluated in this cycle because the EX contents were frozen during the wait; they are re-evaluated next cycle in RUN.
5. State RUN, lu: pc_en = 0, if_id_en = 0, id_ex_flush = 1 (one bubble). Next state is RUN. The bubble clears mem_rd_EX, so the stall lasts exactly one cycle.

Counters:
- stall_cnt increments on every clock where pc_en == 0.
- flush_cnt increments on every clock where id_ex_flush == 1.
- Both saturate at all-ones and never wrap.
- Both reset to 0.

## Timing

- Reset values: state RUN, stall_cnt = 0, flush_cnt = 0. While reset_n is low, outputs are pc_en = if_id_en = id_ex_en = 1 and flushes = 0. Because the pipeline registers are also in reset, the enable values are don't-care.
- Reset asserted mid-stall or mid-redirect: state and counters clear immediately, with no waiting for the clock edge.
- Load-use: exactly 1 stall cycle and 1 bubble. The dependent instruction enters EX 2 cycles after the load.
- Redirect: 2 cycles of IF/ID flush (the redir cycle plus the REDIRECT cycle) and 1 ID/EX bubble.
- Back-to-back redirects: each redir cycle restarts REDIRECT.
- mem_busy for N cycles: N cycles with all stages frozen, then 1 MEM_WAIT release cycle.
- Simultaneous mem_busy and redir: mem_busy wins. redir is honoured once it is re-presented in RUN after the release cycle.
- Simultaneous lu and redir: redir wins, because the ID instruction is on the wrong path.
- Zero-latency paths: pc_en, if_id_en, id_ex_en, if_id_flush and id_ex_flush are combinational from lu, redir and mem_busy within the same cycle.

## Test plan

- Load-use on rs: rd_EX = 5, mem_rd_EX = reg_wr_EX = 1, rs_ID = 5 → pc_en = if_id_en = 0 and id_ex_flush = 1 for 1 cycle. Next cycle all enables are 1. stall_cnt = 1, flush_cnt = 1.
- No hazard cases:
  - rd_EX = 0 with a load and rs_ID = 0 → no stall.
  - rt match with uses_rt_ID = 0 → no stall.
  - reg_wr_EX = 0 → no stall.
- Taken branch: branch_taken_EX pulse for 1 cycle → cycle 0: pc_en = 1, if_id_flush = 1, id_ex_flush = 1. Cycle 1: if_id_flush = 1 only. Cycle 2: RUN defaults. flush_cnt += 1.
- mem_busy held 3 cycles while lu is also true → 3 cycles with all enables 0, then 1 release cycle with all enables 1 and no flush, then RUN re-evaluates lu. stall_cnt = 3 after the release cycle, +1 more if lu is still true in RUN.
- Simultaneous lu and jump_EX → redirect response only; pc_en = 1.
- Reset_n pulsed low asynchronously during REDIRECT, with counters preloaded via traffic → state = RUN and both counters = 0 before the next clock edge. Counter saturation check: CNT_W = 4, 20 stall cycles → stall_cnt holds at 15.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller port bundle: ID/EX hazard inputs in, pipeline enables/flushes and counters out.
// Purely combinational wiring; no storage.
// No backpressure of its own; the controller drives stall/flush towards the pipeline.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs_ID;
    logic [4:0]       rt_ID;
    logic             uses_rt_ID;
    logic [4:0]       rd_EX;
    logic             mem_rd_EX;
    logic             reg_wr_EX;
    logic             jump_EX;
    logic             branch_taken_EX;
    logic             mem_busy;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs_ID, rt_ID, uses_rt_ID, rd_EX, mem_rd_EX, reg_wr_EX,
               jump_EX, branch_taken_EX, mem_busy,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  rs_ID, rt_ID, uses_rt_ID, rd_EX, mem_rd_EX, reg_wr_EX,
               jump_EX, branch_taken_EX, mem_busy,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, EX redirect flush, data-memory freeze, perf counters.
// Enables/flushes are zero-latency (combinational); counters update one clock later.
// mem_busy freezes every stage and overrides redirects and load-use stalls.
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state, state_nxt;
    logic             lu, redir;
    logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    assign lu = hz.mem_rd_EX & hz.reg_wr_EX & (hz.rd_EX != 5'd0) &
                ((hz.rd_EX == hz.rs_ID) | (hz.uses_rt_ID & (hz.rd_EX == hz.rt_ID)));
    assign redir = hz.jump_EX | hz.branch_taken_EX;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        if (reset_n) begin
            if (hz.mem_busy) begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                state_nxt = MEM_WAIT;
            end else if (redir && state != MEM_WAIT) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_nxt   = REDIRECT;
            end else if (state == REDIRECT) begin
                // ID holds the squashed wrong-path slot, so lu is meaningless here
                if_id_flush = 1'b1;
                state_nxt   = RUN;
            end else if (state == MEM_WAIT) begin
                // EX was frozen during the wait; hazards are re-checked next cycle
                state_nxt = RUN;
            end else if (lu) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
            if (id_ex_flush && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

    assign hz.pc_en       = pc_en;
    assign hz.if_id_en    = if_id_en;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_en    = id_ex_en;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.stall_cnt   = stall_cnt;
    assign hz.flush_cnt   = flush_cnt;
endmodule
